i3c_bus_sequencer: RTL

- Controller-side sequencer that owns the SCL/SDA output pair (`scl_o`/`sda_o`, 1 = released/high) and generates bus conditions on command: START, repeated START, single bit transfer, STOP.
- Sits between the I3C controller command logic and the pad interface. Timing is set by programmable phase counters.
- Samples SDA for read data and detects arbitration loss.

---
 rtl/i3c_bus_sequencer_if.sv | 33 +++
 rtl/i3c_bus_sequencer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/i3c_bus_sequencer_if.sv
// Command, status and pad-line bundle between the I3C controller command logic
// and the bus sequencer; master = command/pad side, slave = sequencer.
interface i3c_bus_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             scl_i;
    logic             sda_i;
    logic             scl_o;
    logic             sda_o;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic             cmd_bit;
    logic [CNT_W-1:0] t_low;
    logic [CNT_W-1:0] t_high;
    logic [CNT_W-1:0] t_su;
    logic [CNT_W-1:0] t_hd;
    logic             done;
    logic             rd_bit;
    logic             cmd_err;
    logic             arb_lost;
    logic             bus_busy;

    modport master (
        output scl_i, sda_i, cmd_valid, cmd_op, cmd_bit, t_low, t_high, t_su, t_hd,
        input  scl_o, sda_o, cmd_ready, done, rd_bit, cmd_err, arb_lost, bus_busy
    );

    modport slave (
        input  scl_i, sda_i, cmd_valid, cmd_op, cmd_bit, t_low, t_high, t_su, t_hd,
        output scl_o, sda_o, cmd_ready, done, rd_bit, cmd_err, arb_lost, bus_busy
    );
endinterface

// File: rtl/i3c_bus_sequencer.sv
// I3C controller bus sequencer: generates START / repeated START / bit / STOP on SCL/SDA.
// Optional target clock stretching in the SCL-high phases: I3C_BUS_SEQUENCER_STRETCH_EN.
module i3c_bus_sequencer #(
    parameter int CNT_W = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    i3c_bus_sequencer_if.slave   bus
);
    typedef enum logic [3:0] {
        IDLE, PARK, ST_HD, ST_LOW, RS_LOW, RS_HIGH,
        BIT_LOW, BIT_HIGH, SP_LOW, SP_HIGH, SP_BUF
    } state_t;

    localparam logic [1:0] OP_START  = 2'd0;
    localparam logic [1:0] OP_RSTART = 2'd1;
    localparam logic [1:0] OP_BIT    = 2'd2;
    localparam logic [1:0] OP_STOP   = 2'd3;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bit_q, bit_d;
    logic             scl_q, scl_d, sda_q, sda_d;
    logic             done_q, done_d, err_q, err_d, arb_q, arb_d;
    logic             rd_q, rd_d, busy_q;
    logic             ready, accept, last, tick, phase_end;

    assign ready  = (state_q == IDLE) || (state_q == PARK);
    assign accept = bus.cmd_valid && ready;
    assign last   = (cnt_q <= CNT_W'(1));

`ifdef I3C_BUS_SEQUENCER_STRETCH_EN
    // A target holding SCL low freezes the high-phase count.
    assign tick = bus.scl_i ||
                  !((state_q == BIT_HIGH) || (state_q == RS_HIGH) || (state_q == SP_HIGH));
`else
    logic unused_scl;
    assign unused_scl = bus.scl_i;
    assign tick       = 1'b1;
`endif

    assign phase_end = tick && last;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        rd_d    = rd_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        arb_d   = 1'b0;
        if (!ready && tick && !last) cnt_d = cnt_q - CNT_W'(1);
        unique case (state_q)
            IDLE: if (accept) begin
                if (bus.cmd_op == OP_START) begin
                    state_d = ST_HD;
                    cnt_d   = bus.t_hd;
                end else err_d = 1'b1;
            end
            PARK: if (accept) begin
                cnt_d = bus.t_low;
                unique case (bus.cmd_op)
                    OP_RSTART: state_d = RS_LOW;
                    OP_BIT:    begin state_d = BIT_LOW; bit_d = bus.cmd_bit; end
                    OP_STOP:   state_d = SP_LOW;
                    default:   begin err_d = 1'b1; cnt_d = cnt_q; end
                endcase
            end
            ST_HD:   if (phase_end) begin state_d = ST_LOW;   cnt_d = bus.t_low;  end
            ST_LOW:  if (phase_end) begin state_d = PARK;     cnt_d = '0; done_d = 1'b1; end
            RS_LOW:  if (phase_end) begin state_d = RS_HIGH;  cnt_d = bus.t_su;   end
            RS_HIGH: if (phase_end) begin state_d = ST_HD;    cnt_d = bus.t_hd;   end
            BIT_LOW: if (phase_end) begin state_d = BIT_HIGH; cnt_d = bus.t_high; end
            BIT_HIGH: if (phase_end) begin
                cnt_d  = '0;
                done_d = 1'b1;
                rd_d   = bus.sda_i;
                // Released SDA pulled low by another controller: give up the bus.
                if (bit_q && !bus.sda_i) begin
                    state_d = IDLE;
                    arb_d   = 1'b1;
                end else state_d = PARK;
            end
            SP_LOW:  if (phase_end) begin state_d = SP_HIGH;  cnt_d = bus.t_su;   end
            SP_HIGH: if (phase_end) begin state_d = SP_BUF;   cnt_d = bus.t_hd;   end
            SP_BUF:  if (phase_end) begin state_d = IDLE;     cnt_d = '0; done_d = 1'b1; end
            default: state_d = IDLE;
        endcase
    end

    // Line levels follow the upcoming state; PARK keeps whatever SDA was last driven.
    always_comb begin
        scl_d = 1'b1;
        sda_d = 1'b1;
        unique case (state_d)
            PARK:     begin scl_d = 1'b0; sda_d = sda_q; end
            ST_HD:    begin scl_d = 1'b1; sda_d = 1'b0;  end
            ST_LOW:   begin scl_d = 1'b0; sda_d = 1'b0;  end
            RS_LOW:   begin scl_d = 1'b0; sda_d = 1'b1;  end
            BIT_LOW:  begin scl_d = 1'b0; sda_d = bit_d; end
            BIT_HIGH: begin scl_d = 1'b1; sda_d = bit_d; end
            SP_LOW:   begin scl_d = 1'b0; sda_d = 1'b0;  end
            SP_HIGH:  begin scl_d = 1'b1; sda_d = 1'b0;  end
            default:  begin scl_d = 1'b1; sda_d = 1'b1;  end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 1'b1;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            arb_q   <= 1'b0;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
            done_q  <= done_d;
            err_q   <= err_d;
            arb_q   <= arb_d;
            rd_q    <= rd_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign bus.cmd_ready = ready;
    assign bus.scl_o     = scl_q;
    assign bus.sda_o     = sda_q;
    assign bus.done      = done_q;
    assign bus.cmd_err   = err_q;
    assign bus.arb_lost  = arb_q;
    assign bus.rd_bit    = rd_q;
    assign bus.bus_busy  = busy_q;
endmodule
